branch_redirect_ctrl: RTL

//   Sequences branch/jump resolution for the RV32I core. Accepts one decoded control-transfer op
//   per handshake, evaluates the condition with signed or unsigned compares as fun3 selects, and

---
 rtl/branch_redirect_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves branch/jump ops, issues PC redirect,
// link writeback and a counted fetch/decode flush.
module branch_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_fun3,
    input  logic             br_is_jal,
    input  logic             br_is_jalr,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_rs1,
    input  logic [31:0]      br_rs2,
    input  logic [31:0]      br_imm,
    input  logic             kill,
    output logic             redirect_vld,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             link_vld,
    output logic [31:0]      link_data,
    output logic             misalign_err,
    output logic             illegal_err,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  fun3;
        logic        jal;
        logic        jalr;
    } br_op_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYCLES - 1);

    state_t          state_q;
    state_t          state_d;
    br_op_t          op_q;
    logic [FW-1:0]   fcnt_q;

    logic            accept;
    logic            cond;
    logic            bad_fun3;
    logic            is_jump;
    logic            illegal_op;
    logic            taken;
    logic [31:0]     sum_pc;
    logic [31:0]     sum_rs;
    logic [31:0]     target;
    logic            misal;
    logic            evaling;
    logic            issue;

    assign br_ready = (state_q == S_IDLE);
    assign flush    = (state_q == S_FLUSH);
    assign accept   = br_ready && br_valid && !kill;

    // branch condition decode from the latched fun3
    always_comb begin
        cond     = 1'b0;
        bad_fun3 = 1'b0;
        unique case (op_q.fun3)
            3'b000: cond = (op_q.rs1 == op_q.rs2);
            3'b001: cond = (op_q.rs1 != op_q.rs2);
            3'b100: cond = ($signed(op_q.rs1) < $signed(op_q.rs2));
            3'b101: cond = !($signed(op_q.rs1) < $signed(op_q.rs2));
            3'b110: cond = (op_q.rs1 < op_q.rs2);
            3'b111: cond = !(op_q.rs1 < op_q.rs2);
            3'b010,
            3'b011: bad_fun3 = 1'b1;
        endcase
    end

    // target calculation and resolution of the op in EVAL
    always_comb begin
        is_jump    = op_q.jal || op_q.jalr;
        illegal_op = bad_fun3 && !is_jump;
        taken      = is_jump || (cond && !illegal_op);
        sum_pc     = op_q.pc + op_q.imm;
        sum_rs     = op_q.rs1 + op_q.imm;
        target     = op_q.jalr ? (sum_rs & 32'hFFFF_FFFE) : sum_pc;
        misal      = taken && (target[1:0] != 2'b00);
        evaling    = (state_q == S_EVAL) && !kill;
        issue      = evaling && taken && !misal;
    end

    // next-state logic; kill wins over normal progress
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (kill)       state_d = S_IDLE;
                else if (issue) state_d = S_FLUSH;
                else            state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (kill || fcnt_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // operand capture on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (accept) begin
            op_q.pc   <= br_pc;
            op_q.rs1  <= br_rs1;
            op_q.rs2  <= br_rs2;
            op_q.imm  <= br_imm;
            op_q.fun3 <= br_fun3;
            op_q.jal  <= br_is_jal;
            op_q.jalr <= br_is_jalr;
        end
    end

    // remaining flush cycles after the current one
    always_ff @(posedge clk) begin
        if (rst)                         fcnt_q <= '0;
        else if (issue)                  fcnt_q <= FLAST;
        else if (flush && fcnt_q != '0)  fcnt_q <= fcnt_q - 1'b1;
    end

    // registered single-cycle result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_vld <= 1'b0;
            redirect_pc  <= '0;
            link_vld     <= 1'b0;
            link_data    <= '0;
            misalign_err <= 1'b0;
            illegal_err  <= 1'b0;
        end else begin
            redirect_vld <= issue;
            link_vld     <= issue && is_jump;
            misalign_err <= evaling && misal;
            illegal_err  <= evaling && illegal_op;
            if (issue) redirect_pc <= target;
            if (issue && is_jump) link_data <= op_q.pc + 32'd4;
        end
    end

    // saturating count of issued redirects
    always_ff @(posedge clk) begin
        if (rst)                              taken_cnt <= '0;
        else if (issue && taken_cnt != '1)    taken_cnt <= taken_cnt + 1'b1;
    end

endmodule
